// File: rtl/sram_rsp_pkg.sv
// rtl/sram_rsp_pkg.sv - shared types and constants for the SRAM responder
package sram_rsp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    G_INST = 1'b0,
    G_DATA = 1'b1
  } grant_e;

  localparam logic [31:0] SRAM_RSP_BASE_ADDR = 32'h1c00_0000;

endpackage

// File: rtl/sram_sp.sv
// rtl/sram_sp.sv - single-port synchronous word RAM with registered read data
module sram_sp #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - arbitrated inst/data responder over one single-port RAM
// Optional round-robin tie-break: define SRAM_RSP_FAIR_ARB_EN.
module sram_responder
  import sram_rsp_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = SRAM_RSP_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_done,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  output logic        addr_err,
  output logic [31:0] inst_cnt,
  output logic [31:0] data_cnt
);

  state_e            state_q, state_d;
  grant_e            grant_q, grant_d;
  grant_e            arb_grant;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              oow_q, oow_d;
  logic              inst_done_q, inst_done_d;
  logic              data_done_q, data_done_d;
  logic [31:0]       inst_rdata_q, inst_rdata_d;
  logic [31:0]       data_rdata_q, data_rdata_d;
  logic              addr_err_q, addr_err_d;
  logic [31:0]       inst_cnt_q, inst_cnt_d;
  logic [31:0]       data_cnt_q, data_cnt_d;
`ifdef SRAM_RSP_FAIR_ARB_EN
  grant_e            last_grant_q, last_grant_d;
`endif

  logic [31:0] sel_addr;
  logic [29:0] sel_word;
  logic        sel_oow;
  logic [31:0] ram_rdata;
  logic [31:0] rsp_rdata;
  logic        ram_en;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^{inst_addr[1:0], data_addr[1:0]};

  always_comb begin
    arb_grant = G_DATA;
    if (inst_req && !data_req) begin
      arb_grant = G_INST;
`ifdef SRAM_RSP_FAIR_ARB_EN
    end else if (inst_req && data_req && last_grant_q == G_DATA) begin
      arb_grant = G_INST;
`endif
    end
  end

  // Word offset from the window base; any bit above ADDR_W means out of window.
  assign sel_addr = (arb_grant == G_DATA) ? data_addr : inst_addr;
  assign sel_word = sel_addr[31:2] - BASE_ADDR[31:2];
  assign sel_oow  = |sel_word[29:ADDR_W];

  assign ram_en    = (state_q == ACC) && !oow_q;
  assign rsp_rdata = oow_q ? 32'h0 : ram_rdata;

  sram_sp #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (we_q),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    oow_d        = oow_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    addr_err_d   = addr_err_q;
    inst_cnt_d   = inst_cnt_q;
    data_cnt_d   = data_cnt_q;
`ifdef SRAM_RSP_FAIR_ARB_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          state_d = ACC;
          grant_d = arb_grant;
          we_d    = (arb_grant == G_DATA) && data_we;
          wdata_d = data_wdata;
          idx_d   = sel_word[ADDR_W-1:0];
          oow_d   = sel_oow;
`ifdef SRAM_RSP_FAIR_ARB_EN
          last_grant_d = arb_grant;
`endif
        end
      end
      ACC: begin
        state_d = RESP;
        if (grant_q == G_INST) begin
          inst_done_d = 1'b1;
        end else begin
          data_done_d = 1'b1;
        end
        if (oow_q) begin
          addr_err_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (grant_q == G_INST) begin
          inst_rdata_d = rsp_rdata;
          inst_cnt_d   = inst_cnt_q + 32'd1;
        end else begin
          data_cnt_d = data_cnt_q + 32'd1;
          if (!we_q) begin
            data_rdata_d = rsp_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= G_INST;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0;
      idx_q        <= '0;
      oow_q        <= 1'b0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      addr_err_q   <= 1'b0;
      inst_cnt_q   <= 32'h0;
      data_cnt_q   <= 32'h0;
`ifdef SRAM_RSP_FAIR_ARB_EN
      last_grant_q <= G_INST;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      oow_q        <= oow_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      addr_err_q   <= addr_err_d;
      inst_cnt_q   <= inst_cnt_d;
      data_cnt_q   <= data_cnt_d;
`ifdef SRAM_RSP_FAIR_ARB_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // The RAM read lands during RESP, so the done cycle shows it straight from the RAM.
  assign inst_rdata = (state_q == RESP && grant_q == G_INST) ? rsp_rdata : inst_rdata_q;
  assign data_rdata = (state_q == RESP && grant_q == G_DATA && !we_q) ? rsp_rdata : data_rdata_q;
  assign inst_done  = inst_done_q;
  assign data_done  = data_done_q;
  assign addr_err   = addr_err_q;
  assign inst_cnt   = inst_cnt_q;
  assign data_cnt   = data_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - directed table-driven bench for sram_responder
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        addr_err;
  logic [31:0] inst_cnt;
  logic [31:0] data_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vt[13];

  sram_responder dut (
    .clk        (clk),
    .reset      (reset),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_done  (inst_done),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_done  (data_done),
    .addr_err   (addr_err),
    .inst_cnt   (inst_cnt),
    .data_cnt   (data_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic access(input bit is_data, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    @(negedge clk);
    if (is_data) begin
      data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if ((is_data && data_done) || (!is_data && inst_done)) begin
        lat = c;
        break;
      end
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    data_we  = 1'b0;
  endtask

  task automatic collide(input logic [31:0] iaddr, input logic [31:0] daddr,
                         output int i_at, output int d_at,
                         output logic [31:0] i_rd, output logic [31:0] d_rd);
    @(negedge clk);
    inst_req = 1'b1; inst_addr = iaddr;
    data_req = 1'b1; data_we = 1'b0; data_addr = daddr;
    i_at = 0; d_at = 0; i_rd = 32'h0; d_rd = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (data_done) begin
        d_at = c; d_rd = data_rdata; data_req = 1'b0;
      end
      if (inst_done) begin
        i_at = c; i_rd = inst_rdata; inst_req = 1'b0;
      end
      if (i_at != 0 && d_at != 0) break;
    end
    inst_req = 1'b0;
    data_req = 1'b0;
  endtask

  initial begin
    int          lat;
    int          i_at, d_at;
    logic [31:0] i_rd, d_rd;
    logic [31:0] exp_icnt, exp_dcnt;
    bit          seen_done;

    vt[0]  = '{1'b1, 1'b1, 32'h1c00_0010, 32'hdead_beef, 32'h0000_0000, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 32'h1c00_0010, 32'h0,         32'hdead_beef, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 32'h1c00_0013, 32'h0,         32'hdead_beef, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 32'h1c00_fffc, 32'ha5a5_0001, 32'hdead_beef, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 32'h1c00_fffc, 32'h0,         32'ha5a5_0001, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 32'h1c00_0000, 32'h0000_1111, 32'hdead_beef, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 32'h1c00_0010, 32'h0,         32'hdead_beef, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 32'h1c00_0000, 32'h0,         32'h0000_1111, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 32'h1c01_0000, 32'h7777_7777, 32'h0000_0000, 1'b1};
    vt[10] = '{1'b1, 1'b0, 32'h1c00_fffc, 32'h0,         32'ha5a5_0001, 1'b1};
    vt[11] = '{1'b0, 1'b0, 32'h1c00_0000, 32'h0,         32'h0000_1111, 1'b1};
    vt[12] = '{1'b0, 1'b0, 32'h1bff_fffc, 32'h0,         32'h0000_0000, 1'b1};

    reset = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_addr = 32'h0; data_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_inst_done", {31'h0, inst_done}, 32'h0);
    chk("rst_data_done", {31'h0, data_done}, 32'h0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
    chk("rst_inst_cnt", inst_cnt, 32'h0);
    chk("rst_data_cnt", data_cnt, 32'h0);
    reset = 1'b0;

    exp_icnt = 32'h0;
    exp_dcnt = 32'h0;
    for (int i = 0; i < 13; i++) begin
      access(vt[i].is_data, vt[i].we, vt[i].addr, vt[i].wdata, lat);
      chk($sformatf("vec%0d_latency", i), lat, 32'd2);
      if (vt[i].is_data) begin
        chk($sformatf("vec%0d_data_rdata", i), data_rdata, vt[i].exp_rdata);
        exp_dcnt++;
      end else begin
        chk($sformatf("vec%0d_inst_rdata", i), inst_rdata, vt[i].exp_rdata);
        exp_icnt++;
      end
      chk($sformatf("vec%0d_addr_err", i), {31'h0, addr_err}, {31'h0, vt[i].exp_err});
    end
    @(negedge clk);
    chk("table_inst_cnt", inst_cnt, exp_icnt);
    chk("table_data_cnt", data_cnt, exp_dcnt);

    // Tie after an inst grant: both builds serve data first.
    collide(32'h1c00_fffc, 32'h1c00_0010, i_at, d_at, i_rd, d_rd);
    chk("coll1_data_at", d_at, 32'd2);
    chk("coll1_inst_at", i_at, 32'd5);
    chk("coll1_data_rd", d_rd, 32'hdead_beef);
    chk("coll1_inst_rd", i_rd, 32'ha5a5_0001);
    exp_icnt++; exp_dcnt++;

    access(1'b1, 1'b0, 32'h1c00_0000, 32'h0, lat);
    chk("solo_data_lat", lat, 32'd2);
    chk("solo_data_rd", data_rdata, 32'h0000_1111);
    exp_dcnt++;

    // Tie right after a data grant: round-robin flips the order.
    collide(32'h1c00_0010, 32'h1c00_fffc, i_at, d_at, i_rd, d_rd);
`ifdef SRAM_RSP_FAIR_ARB_EN
    chk("coll2_inst_at", i_at, 32'd2);
    chk("coll2_data_at", d_at, 32'd5);
`else
    chk("coll2_data_at", d_at, 32'd2);
    chk("coll2_inst_at", i_at, 32'd5);
`endif
    chk("coll2_inst_rd", i_rd, 32'hdead_beef);
    chk("coll2_data_rd", d_rd, 32'ha5a5_0001);
    exp_icnt++; exp_dcnt++;
    @(negedge clk);
    chk("coll_inst_cnt", inst_cnt, exp_icnt);
    chk("coll_data_cnt", data_cnt, exp_dcnt);

    @(negedge clk);
    force dut.inst_cnt_q = 32'hffff_ffff;
    @(negedge clk);
    release dut.inst_cnt_q;
    chk("wrap_forced", inst_cnt, 32'hffff_ffff);
    access(1'b0, 1'b0, 32'h1c00_0010, 32'h0, lat);
    chk("wrap_lat", lat, 32'd2);
    @(negedge clk);
    chk("wrap_inst_cnt", inst_cnt, 32'h0);
    chk("wrap_data_cnt", data_cnt, exp_dcnt);

    @(negedge clk);
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h1c00_0010; data_wdata = 32'h1234_5678;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_inst_done", {31'h0, inst_done}, 32'h0);
    chk("midrst_data_done", {31'h0, data_done}, 32'h0);
    chk("midrst_inst_rdata", inst_rdata, 32'h0);
    chk("midrst_data_rdata", data_rdata, 32'h0);
    chk("midrst_addr_err", {31'h0, addr_err}, 32'h0);
    chk("midrst_inst_cnt", inst_cnt, 32'h0);
    chk("midrst_data_cnt", data_cnt, 32'h0);
    data_req = 1'b0; data_we = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (data_done || inst_done) seen_done = 1'b1;
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (data_done || inst_done) seen_done = 1'b1;
    end
    chk("midrst_no_done", {31'h0, seen_done}, 32'h0);
    access(1'b1, 1'b0, 32'h1c00_0010, 32'h0, lat);
    chk("midrst_read_lat", lat, 32'd2);
    chk("midrst_old_word", data_rdata, 32'hdead_beef);
    chk("midrst_err_clear", {31'h0, addr_err}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the CPU's instruction and data SRAM ports. Serves both requesters from one single-port synchronous word RAM, arbitrates between them, and returns a one-cycle done pulse per completed access. The CPU's multi-cycle state machine waits for this pulse. Sits beside the CPU top in the SoC and replaces separate ideal SRAMs.

## Interface
- ADDR_W, 14: word-index width; RAM holds 2**ADDR_W 32-bit words.
- BASE_ADDR, 32'h1c00_0000: byte address of word 0. The window is BASE_ADDR .. BASE_ADDR + 4*2**ADDR_W - 1.
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  instruction read request; held high until inst_done is seen.
- inst_addr  in  32  instruction byte address; bits [1:0] are ignored.
- inst_rdata  out  32  read word; holds its value until the next inst response.
- inst_done  out  1  one-cycle pulse; inst_rdata is valid.
- data_req  in  1  data request; held high until data_done is seen.
- data_we  in  1  1 = full-word write, 0 = read.
- data_addr  in  32  data byte address; bits [1:0] are ignored.
- data_wdata  in  32  write word.
- data_rdata  out  32  read word; holds its value until the next data read response.
- data_done  out  1  one-cycle pulse; read data is valid or the write has been committed.
- addr_err  out  1  sticky flag; set by any out-of-window access.
- inst_cnt, data_cnt  out  32 each  completed-access counters; wrap modulo 2**32.

## Operation
- FSM states:
  - IDLE: the only state in which requests are sampled.
  - ACC: the latched access is presented to the RAM.
  - RESP: the done pulse is driven.
- IDLE → ACC when either request is high. On this transition latch:
  - the grant (inst or data),
  - the address, we, and wdata of the granted port.
- ACC → RESP unconditionally:
  - the RAM performs the read or write at this edge;
  - the read result is registered into the granted port's rdata.
- RESP → IDLE unconditionally:
  - the granted port's done is 1 for exactly this cycle;
  - the counter of the granted port increments at the edge leaving RESP.
- The requester must deassert req before the next IDLE cycle. A req still high in IDLE is treated as a new access.
- Word index = (addr - BASE_ADDR) >> 2.
- Out-of-window address:
  - a read returns 32'h0;
  - a write is dropped;
  - done still pulses;
  - addr_err is set and stays set until reset.
- Arbitration when both requests are high in IDLE: data wins (default). See Configuration for the alternative.
- Read-after-write to the same word returns the new value, since accesses are serialized.
- Write on the data port: data_rdata is unchanged.

## Timing
- Request in cycle 0 (IDLE) → state ACC in cycle 1 → done=1 in cycle 2 → IDLE in cycle 3.
- Latency from req to done: 2 cycles.
- Minimum spacing between accesses: 3 cycles.
- Reset values:
  - state IDLE;
  - inst_done and data_done 0;
  - inst_rdata and data_rdata 32'h0;
  - addr_err 0;
  - inst_cnt and data_cnt 0.
- RAM contents are not reset.
- Reset asserted mid-operation:
  - the FSM returns to IDLE immediately and asynchronously;
  - a write still in ACC when reset asserts is not committed;
  - no done pulse is produced for the aborted access.
- A request arriving in ACC or RESP is not lost; it is seen in the next IDLE cycle because req is held.

## Configuration
- SRAM_RSP_FAIR_ARB_EN defined:
  - round-robin arbitration;
  - a last_grant register (reset: inst) records the previous grant;
  - on a tie, the port not granted last wins.
- Not defined: fixed data-over-inst priority; no last_grant register.
- Behaviour with a single requester is identical in both builds.

## Structure
- Package sram_rsp_pkg holds:
  - the FSM state enum (IDLE, ACC, RESP);
  - the grant enum (G_INST, G_DATA);
  - the default BASE_ADDR constant.
- Sub-module sram_sp:
  - single-port synchronous RAM, parameter ADDR_W;
  - ports clk, en, we, addr, wdata, rdata;
  - read data is registered;
  - no reset on the array.
- The top level contains the FSM, arbiter, window check, output registers, and counters.

## Test plan
- Write then read the same word:
  - data write 32'hdead_beef at 32'h1c00_0010 → data_done in cycle 2;
  - data read of the same address → data_rdata = 32'hdead_beef in its done cycle.
- Collision: inst_req and data_req both rise in the same IDLE cycle.
  - Default build: data done at cycle 2, inst done at cycle 5.
  - FAIR build after a previous data grant: inst first, then data.
- Out-of-window access:
  - read at 32'h0000_0000 → data_rdata = 0, addr_err = 1;
  - a subsequent in-window access completes normally and addr_err stays 1.
- Reset mid-write:
  - assert reset while in ACC for a write of 32'h1234_5678;
  - after reset, a read returns the old word;
  - no done pulse; all outputs at their reset values.
- Counter wrap: force inst_cnt to 32'hffff_ffff; one inst access → 0.
